// File: rtl/sa_rd_stage_fifo.sv
// Staging FIFO between the read-DMA stream and the systolic array engine.
// First-word-fall-through with a registered head; also reports burst completion and space for a burst.
module sa_rd_stage_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int BIT_TRANS = 8,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic [BIT_TRANS-1:0] i_burst_len,
  input  logic [DATA_W-1:0]    i_s_data,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  output logic [DATA_W-1:0]    o_m_data,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [AW:0]          o_level,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_space_ok,
  output logic                 o_burst_done,
  output logic                 o_overflow
);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          level;
  logic [AW:0]          avail;
  logic [AW:0]          free;
  logic [BIT_TRANS-1:0] pop_cnt;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 flush;

  assign flush = rst || i_clear;
  assign push  = i_s_valid && o_s_ready;
  assign pop   = o_m_valid && i_m_ready;

  // Level counts the head register too; avail is what still sits only in memory.
  assign avail = level - {{AW{1'b0}}, o_m_valid};
  assign load  = (avail != '0) && (!o_m_valid || pop);

  assign o_level   = level;
  assign o_full    = (level == (AW+1)'(DEPTH));
  assign o_empty   = (level == '0);
  assign o_s_ready = !o_full;
  assign free      = (AW+1)'(DEPTH) - level;
  assign o_space_ok = (32'(free) >= 32'(i_burst_len));

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= i_s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pop_cnt      <= '0;
      o_m_data     <= '0;
      o_m_valid    <= 1'b0;
      o_burst_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (load) begin
        o_m_data  <= mem[rd_ptr];
        o_m_valid <= 1'b1;
        rd_ptr    <= rd_ptr + AW'(1);
      end else if (pop) begin
        o_m_valid <= 1'b0;
      end

      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase

      if (i_s_valid && !o_s_ready) begin
        o_overflow <= 1'b1;
      end

      o_burst_done <= 1'b0;
      if (pop && (i_burst_len != '0)) begin
        if (({1'b0, pop_cnt} + (BIT_TRANS+1)'(1)) == {1'b0, i_burst_len}) begin
          o_burst_done <= 1'b1;
          pop_cnt      <= '0;
        end else begin
          pop_cnt <= pop_cnt + BIT_TRANS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_rd_stage_fifo.sv
// Scoreboard bench for sa_rd_stage_fifo: queue-based reference model checked every cycle.
module tb_sa_rd_stage_fifo;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 32;
  localparam int BIT_TRANS = 8;
  localparam int AW        = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_clear;
  logic [BIT_TRANS-1:0] i_burst_len;
  logic [DATA_W-1:0]    i_s_data;
  logic                 i_s_valid;
  logic                 o_s_ready;
  logic [DATA_W-1:0]    o_m_data;
  logic                 o_m_valid;
  logic                 i_m_ready;
  logic [AW:0]          o_level;
  logic                 o_full;
  logic                 o_empty;
  logic                 o_space_ok;
  logic                 o_burst_done;
  logic                 o_overflow;

  sa_rd_stage_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BIT_TRANS(BIT_TRANS)) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_burst_len(i_burst_len),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .o_level(o_level), .o_full(o_full), .o_empty(o_empty),
    .o_space_ok(o_space_ok), .o_burst_done(o_burst_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: words held in FIFO order, plus flags for the next cycle.
  logic [DATA_W-1:0] exp_q[$];
  int pushed_last = 0;
  int bcnt = 0;
  bit done_exp = 0;
  bit ovf_exp = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT state against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit exp_valid, push, pop;
    int held;
    if (rst) begin
      exp_q.delete();
      pushed_last = 0; bcnt = 0; done_exp = 0; ovf_exp = 0;
    end else begin
      held = exp_q.size();
      exp_valid = (held - pushed_last) > 0;
      chk("level", 32'(o_level), held);
      chk("m_valid", 32'(o_m_valid), 32'(exp_valid));
      if (o_m_valid && held > 0) chk("m_data", o_m_data, exp_q[0]);
      chk("full", 32'(o_full), 32'(held == DEPTH));
      chk("empty", 32'(o_empty), 32'(held == 0));
      chk("s_ready", 32'(o_s_ready), 32'(held < DEPTH));
      chk("space_ok", 32'(o_space_ok), 32'((DEPTH - held) >= int'(i_burst_len)));
      chk("overflow", 32'(o_overflow), 32'(ovf_exp));
      chk("burst_done", 32'(o_burst_done), 32'(done_exp));
      if (o_burst_done) done_cnt++;

      if (i_clear) begin
        exp_q.delete();
        pushed_last = 0; bcnt = 0; done_exp = 0; ovf_exp = 0;
      end else begin
        push = i_s_valid && (held < DEPTH);
        pop  = exp_valid && i_m_ready;
        done_exp = 0;
        if (pop) begin
          void'(exp_q.pop_front());
          if (i_burst_len != 0) begin
            bcnt++;
            if (bcnt == int'(i_burst_len)) begin
              done_exp = 1;
              bcnt = 0;
            end
          end
        end
        if (push) exp_q.push_back(i_s_data);
        if (i_s_valid && !(held < DEPTH)) ovf_exp = 1;
        pushed_last = push ? 1 : 0;
      end
    end
  end

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit c);
    i_s_valid = v; i_s_data = d; i_m_ready = r; i_clear = c;
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd);
    int k = 0;
    while ((exp_q.size() != 0 || o_m_valid) && k < 500) begin
      drive(0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 0);
      k++;
    end
    chk("drain_empty", 32'(o_m_valid), 0);
  endtask

  initial begin
    int sent, cyc;
    bit v;
    rst = 1; i_clear = 0; i_burst_len = 16; i_s_data = '0; i_s_valid = 0; i_m_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_data", o_m_data, 0);
    chk("rst_level", 32'(o_level), 0);
    chk("rst_space_ok", 32'(o_space_ok), 1);

    // Burst of 16 with the engine always ready.
    done_cnt = 0;
    drive(1, 32'h100, 1, 0);
    chk("p1_latency_0", 32'(o_m_valid), 0);
    drive(1, 32'h101, 1, 0);
    chk("p1_latency_1", 32'(o_m_valid), 1);
    chk("p1_first_word", o_m_data, 32'h100);
    for (int i = 2; i < 16; i++) drive(1, 32'h100 + i, 1, 0);
    repeat (4) drive(0, '0, 1, 0);
    chk("p1_pulses", done_cnt, 1);
    chk("p1_level", 32'(o_level), 0);

    // Fill to full, then one word too many.
    for (int i = 0; i < 32; i++) drive(1, 32'h200 + i, 0, 0);
    chk("p2_full", 32'(o_full), 1);
    chk("p2_level", 32'(o_level), 32);
    chk("p2_space_ok", 32'(o_space_ok), 0);
    drive(1, 32'hDEAD, 0, 0);
    chk("p2_overflow", 32'(o_overflow), 1);

    // Pop half, refill across the pointer wrap, drain everything.
    for (int i = 0; i < 16; i++) drive(0, '0, 1, 0);
    chk("p3_level", 32'(o_level), 16);
    chk("p3_space_ok", 32'(o_space_ok), 1);
    for (int i = 0; i < 16; i++) drive(1, 32'h300 + i, 0, 0);
    drain(0);

    // Random backpressure, 256 random words.
    drive(0, '0, 0, 1);
    done_cnt = 0; sent = 0; cyc = 0;
    while (sent < 256 && cyc < 4000) begin
      v = o_s_ready;
      drive(v, $urandom, 1'($urandom_range(0, 1)), 0);
      if (v) sent++;
      cyc++;
    end
    chk("p4_sent", sent, 256);
    drain(1);
    repeat (3) drive(0, '0, 0, 0);
    chk("p4_pulses", done_cnt, 16);

    // Clear coincident with a push and a pop.
    drive(0, '0, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, 32'h500 + i, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, '0, 1, 0);
    drive(1, 32'h5FF, 1, 1);
    chk("p5_level", 32'(o_level), 0);
    chk("p5_valid", 32'(o_m_valid), 0);
    chk("p5_overflow", 32'(o_overflow), 0);
    done_cnt = 0;
    for (int i = 0; i < 16; i++) drive(1, 32'h600 + i, 1, 0);
    repeat (4) drive(0, '0, 1, 0);
    chk("p5_pulses", done_cnt, 1);

    // Burst counter disabled, then a burst longer than the buffer.
    drive(0, '0, 0, 1);
    i_burst_len = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) drive(1, 32'h700 + i, 1, 0);
    repeat (4) drive(0, '0, 1, 0);
    chk("p6_no_pulses", done_cnt, 0);
    i_burst_len = 40;
    #1 chk("p6_space_empty", 32'(o_space_ok), 0);
    for (int i = 0; i < 10; i++) drive(1, 32'h800 + i, 0, 0);
    chk("p6_space_10", 32'(o_space_ok), 0);
    drain(0);
    repeat (2) drive(0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
